// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and EX forwarding control.
// Ports: clk/reset, decode fields in, stall/flush_id/fwd_a/fwd_b, ex/mem/wb_rd, stall_cnt out.
module hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16,
   parameter int FWD_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_is_load,
   input  logic              ex_br_taken,
   output logic              stall,
   output logic              flush_id,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [REG_AW-1:0] ex_rd,
   output logic [REG_AW-1:0] mem_rd,
   output logic [REG_AW-1:0] wb_rd,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              ld;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
   } ent_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   ent_t ex_q, mem_q, wb_q, id_e;
   logic haz_ex, haz_mem, haz_wb, stall_raw;
   logic unused_ok;

   function automatic logic hit(input ent_t s, input logic [REG_AW-1:0] r);
      return s.v & s.we & (s.rd != '0) & (s.rd == r);
   endfunction

   // MEM wins over WB: it holds the younger producer.
   // A load in MEM has no data yet, so it cannot forward.
   function automatic logic [1:0] fsel(input logic [REG_AW-1:0] rs,
                                       input ent_t m, input ent_t w);
      if (hit(m, rs) && !m.ld) return 2'b01;
      else if (hit(w, rs)) return 2'b10;
      else return 2'b00;
   endfunction

   function automatic logic haz(input ent_t s, input logic v,
                                input logic u1, input logic [REG_AW-1:0] r1,
                                input logic u2, input logic [REG_AW-1:0] r2);
      return v & ((u1 & hit(s, r1)) | (u2 & hit(s, r2)));
   endfunction

   assign haz_ex  = haz(ex_q,  id_valid, id_use_rs1, id_rs1, id_use_rs2, id_rs2);
   assign haz_mem = haz(mem_q, id_valid, id_use_rs1, id_rs1, id_use_rs2, id_rs2);
   assign haz_wb  = haz(wb_q,  id_valid, id_use_rs1, id_rs1, id_use_rs2, id_rs2);

   // Without forwarding every in-flight producer blocks the consumer.
   assign stall_raw = (FWD_EN != 0) ? (haz_ex & ex_q.ld)
                                    : (haz_ex | haz_mem | haz_wb);
   // Taken branch squashes the decode instruction, so it must not stall.
   assign stall    = stall_raw & ~ex_br_taken;
   assign flush_id = ex_br_taken;

   assign fwd_a = (FWD_EN != 0) ? fsel(ex_q.rs1, mem_q, wb_q) : 2'b00;
   assign fwd_b = (FWD_EN != 0) ? fsel(ex_q.rs2, mem_q, wb_q) : 2'b00;

   assign ex_rd  = ex_q.v  ? ex_q.rd  : '0;
   assign mem_rd = mem_q.v ? mem_q.rd : '0;
   assign wb_rd  = wb_q.v  ? wb_q.rd  : '0;

   always_comb begin
      id_e     = '0;
      id_e.v   = 1'b1;
      id_e.rd  = id_rd;
      id_e.we  = id_reg_write;
      id_e.ld  = id_is_load;
      id_e.rs1 = id_rs1;
      id_e.rs2 = id_rs2;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         stall_cnt <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         if (ex_br_taken || stall || !id_valid) ex_q <= '0;
         else ex_q <= id_e;
         if (stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

   assign unused_ok = ^{mem_q.rs1, mem_q.rs2, wb_q.rs1, wb_q.rs2, wb_q.ld};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: random decode stream into a forwarding and a
// non-forwarding (2-bit counter) instance, checked against a stage-list model.
module tb_hazard_ctrl;

   typedef struct {
      bit       v;
      int       rd;
      bit       we;
      bit       ld;
      int       rs1;
      int       rs2;
   } ment_t;

   logic       clk = 0;
   logic       reset;
   logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
   logic       ex_br_taken;
   logic [4:0] id_rs1, id_rs2, id_rd;

   logic       a_stall, a_flush, b_stall, b_flush;
   logic [1:0] a_fa, a_fb, b_fa, b_fb;
   logic [4:0] a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
   logic [15:0] a_cnt;
   logic [1:0]  b_cnt;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut_a (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .ex_br_taken(ex_br_taken), .stall(a_stall), .flush_id(a_flush),
      .fwd_a(a_fa), .fwd_b(a_fb), .ex_rd(a_ex), .mem_rd(a_mem),
      .wb_rd(a_wb), .stall_cnt(a_cnt)
   );

   hazard_ctrl #(.FWD_EN(0), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .ex_br_taken(ex_br_taken), .stall(b_stall), .flush_id(b_flush),
      .fwd_a(b_fa), .fwd_b(b_fb), .ex_rd(b_ex), .mem_rd(b_mem),
      .wb_rd(b_wb), .stall_cnt(b_cnt)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // pipe[d][0]=EX, [1]=MEM, [2]=WB; plain list of in-flight instructions
   ment_t pipe[2][3];
   int    cnt[2];
   int    cmax[2] = '{65535, 3};
   bit    fen[2]  = '{1'b1, 1'b0};
   ment_t empty_e = '{0, 0, 0, 0, 0, 0};

   function automatic bit writes_to(ment_t e, int r);
      return e.v && e.we && e.rd != 0 && e.rd == r;
   endfunction

   function automatic bit blocks(ment_t e);
      bit r1, r2;
      r1 = id_use_rs1 && writes_to(e, int'(id_rs1));
      r2 = id_use_rs2 && writes_to(e, int'(id_rs2));
      return id_valid && (r1 || r2);
   endfunction

   function automatic int src(int d, int rs);
      if (!fen[d]) return 0;
      if (writes_to(pipe[d][1], rs) && !pipe[d][1].ld) return 1;
      if (writes_to(pipe[d][2], rs)) return 2;
      return 0;
   endfunction

   function automatic bit want_stall(int d);
      bit s;
      s = 0;
      if (fen[d]) s = blocks(pipe[d][0]) && pipe[d][0].ld;
      else for (int k = 0; k < 3; k++) s |= blocks(pipe[d][k]);
      return s && !ex_br_taken;
   endfunction

   function automatic int rd_of(ment_t e);
      return e.v ? e.rd : 0;
   endfunction

   initial begin
      bit es[2];
      int o_st[2], o_fa[2], o_fb[2], o_ex[2], o_mem[2], o_wb[2], o_cnt[2];
      reset = 1;
      id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_reg_write = 0; id_is_load = 0; ex_br_taken = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         reset        = (cyc < 2) || ($urandom_range(0, 99) == 0);
         id_valid     = $urandom_range(0, 9) != 0;
         id_rs1       = 5'($urandom_range(0, 7));
         id_rs2       = 5'($urandom_range(0, 7));
         id_rd        = 5'($urandom_range(0, 7));
         id_use_rs1   = $urandom_range(0, 9) < 7;
         id_use_rs2   = $urandom_range(0, 9) < 6;
         id_reg_write = $urandom_range(0, 9) < 8;
         id_is_load   = $urandom_range(0, 9) < 3;
         ex_br_taken  = $urandom_range(0, 9) == 0;
         #1;
         o_st  = '{int'(a_stall), int'(b_stall)};
         o_fa  = '{int'(a_fa), int'(b_fa)};
         o_fb  = '{int'(a_fb), int'(b_fb)};
         o_ex  = '{int'(a_ex), int'(b_ex)};
         o_mem = '{int'(a_mem), int'(b_mem)};
         o_wb  = '{int'(a_wb), int'(b_wb)};
         o_cnt = '{int'(a_cnt), int'(b_cnt)};
         check("flush_id_a", int'(a_flush), int'(ex_br_taken));
         check("flush_id_b", int'(b_flush), int'(ex_br_taken));
         for (int d = 0; d < 2; d++) begin
            es[d] = want_stall(d);
            if (cyc >= 2) begin
               string t;
               t = $sformatf("d%0d c%0d", d, cyc);
               if (!reset) check({"stall ", t}, o_st[d], int'(es[d]));
               check({"fwd_a ", t}, o_fa[d], src(d, pipe[d][0].rs1));
               check({"fwd_b ", t}, o_fb[d], src(d, pipe[d][0].rs2));
               check({"ex_rd ", t}, o_ex[d], rd_of(pipe[d][0]));
               check({"mem_rd ", t}, o_mem[d], rd_of(pipe[d][1]));
               check({"wb_rd ", t}, o_wb[d], rd_of(pipe[d][2]));
               check({"stall_cnt ", t}, o_cnt[d], cnt[d]);
            end
         end
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            if (reset) begin
               pipe[d] = '{empty_e, empty_e, empty_e};
               cnt[d] = 0;
            end else begin
               pipe[d][2] = pipe[d][1];
               pipe[d][1] = pipe[d][0];
               if (ex_br_taken || es[d] || !id_valid) pipe[d][0] = empty_e;
               else pipe[d][0] = '{1, int'(id_rd), id_reg_write, id_is_load,
                                   int'(id_rs1), int'(id_rs2)};
               if (es[d] && cnt[d] < cmax[d]) cnt[d]++;
            end
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
